// File: rtl/cla_sub_pipe.sv
// cla_sub_pipe: two-stage pipelined carry-lookahead subtractor, a - b - b_in.
// Stage 1 registers the propagate/generate terms; stage 2 resolves the carries
// with per-group two-level lookahead and registers diff, borrow and overflow.
// Valid/ready handshakes on both sides; the pipeline holds at most two results.
// Optional macro CLA_SUB_SAT_EN: unsigned saturation, diff forced to 0 on borrow.
module cla_sub_pipe #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf
);

    localparam int NGRP = WIDTH / 4;

    // Stage 1 state: propagate/generate of a + ~b, and the carry-in ~b_in
    logic [WIDTH-1:0] p_p1;
    logic [WIDTH-1:0] g_p1;
    logic             c0_p1;
    logic             vld_p1;

    // Stage 2 state: registered result
    logic [WIDTH-1:0] diff_p2;
    logic             bout_p2;
    logic             ovf_p2;
    logic             vld_p2;

    logic             ld_p1;
    logic             ld_p2;
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] diff_n;
    logic [WIDTH-1:0] diff_sel;
    logic             bout_n;
    logic             ovf_n;

`ifdef CLA_SUB_SAT_EN
    // Unsigned saturation: an underflowing difference clamps to zero.
    function automatic logic [WIDTH-1:0] sat_diff(input logic [WIDTH-1:0] d,
                                                  input logic             brw);
        return brw ? '0 : d;
    endfunction
`endif

    // A stage may load when it is empty or its content moves on this cycle;
    // in_ready therefore depends combinationally on out_ready.
    always_comb begin
        ld_p2    = !vld_p2 || out_ready;
        ld_p1    = !vld_p1 || ld_p2;
        in_ready = ld_p1;
    end

    // ---- input -> stage 1 boundary ----
    // Capture p/g/c0 on an input handshake; valid clears when content drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            p_p1   <= '0;
            g_p1   <= '0;
            c0_p1  <= 1'b0;
        end else if (ld_p1) begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                p_p1  <= a ^ ~b;
                g_p1  <= a & ~b;
                c0_p1 <= ~b_in;
            end
        end
    end

    // Per 4-bit group, two-level lookahead carries; group carry-out ripples on.
    always_comb begin
        logic       cg;
        logic [3:0] gp;
        logic [3:0] gg;
        c    = '0;
        c[0] = c0_p1;
        cg   = c0_p1;
        gp   = '0;
        gg   = '0;
        for (int k = 0; k < NGRP; k++) begin
            gp = p_p1[4*k +: 4];
            gg = g_p1[4*k +: 4];
            c[4*k+1] = gg[0] | (gp[0] & cg);
            c[4*k+2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cg);
            c[4*k+3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                     | (gp[2] & gp[1] & gp[0] & cg);
            cg       = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                     | (gp[3] & gp[2] & gp[1] & gg[0])
                     | (gp[3] & gp[2] & gp[1] & gp[0] & cg);
            c[4*k+4] = cg;
        end
        diff_n = p_p1 ^ c[WIDTH-1:0];
        bout_n = ~c[WIDTH];
        ovf_n  = c[WIDTH] ^ c[WIDTH-1];
`ifdef CLA_SUB_SAT_EN
        diff_sel = sat_diff(diff_n, bout_n);
`else
        diff_sel = diff_n;
`endif
    end

    // ---- stage 1 -> stage 2 (output) boundary ----
    // Register the result; hold it unchanged while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2  <= 1'b0;
            diff_p2 <= '0;
            bout_p2 <= 1'b0;
            ovf_p2  <= 1'b0;
        end else if (ld_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                diff_p2 <= diff_sel;
                bout_p2 <= bout_n;
                ovf_p2  <= ovf_n;
            end
        end
    end

    assign out_valid = vld_p2;
    assign diff      = diff_p2;
    assign b_out     = bout_p2;
    assign ovf       = ovf_p2;

endmodule

// File: tb/tb_cla_sub_pipe.sv
// tb_cla_sub_pipe: scoreboard bench for cla_sub_pipe (WIDTH = 4).
// Accepted operands push an arithmetic-model result; a monitor pops and
// compares whenever a result is handed over.
module tb_cla_sub_pipe;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         b_in = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] diff;
    logic         b_out;
    logic         ovf;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [W+1:0] sb_q[$];
    logic         stall_prev = 1'b0;
    logic [W+1:0] stall_val  = '0;
    bit           rnd_on     = 1'b0;

    cla_sub_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .b_out     (b_out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma,
                                           input logic [W-1:0] mb,
                                           input logic         mbi);
        int ua, ub, sa, sb, ud, sd;
        logic [W-1:0] d;
        logic bo, ov;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        ud = ua - ub - int'(mbi);
        sd = sa - sb - int'(mbi);
        d  = ud[W-1:0];
        bo = (ua < ub + int'(mbi));
        ov = (sd < -(1 << (W-1))) || (sd > (1 << (W-1)) - 1);
`ifdef CLA_SUB_SAT_EN
        if (bo) d = '0;
`endif
        return {d, bo, ov};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: samples mid-cycle, the values the next rising edge will act on.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) check("stall_hold", {out_valid, diff, b_out, ovf}, {1'b1, stall_val});
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got diff=%0d with empty scoreboard", diff);
                end else begin
                    check("result", {diff, b_out, ovf}, sb_q.pop_front());
                end
            end
            if (in_valid && in_ready) sb_q.push_back(model(a, b, b_in));
            stall_prev = out_valid && !out_ready;
            stall_val  = {diff, b_out, ovf};
        end
    end

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbi);
        bit done;
        int n;
        done = 1'b0;
        n = 0;
        a = ta;
        b = tb;
        b_in = tbi;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 100) begin
                total++;
                bad++;
                $display("FAIL send_timeout: in_ready stuck at 0 for %0d cycles, required 1", n);
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", sb_q.size(), 0);
    endtask

    initial begin
        int k, c0;
        bit hs;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", diff, 0);
        check("rst_b_out", b_out, 0);
        check("rst_ovf", ovf, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Basic subtract with latency check on an empty pipe
        send(4'd5, 4'd3, 1'b0);
        @(negedge clk);
        check("lat_n1_valid", out_valid, 0);
        @(negedge clk);
        check("lat_n2_valid", out_valid, 1);
        check("basic_diff", diff, 2);
        @(posedge clk);
        #1;
        drain();

        // Borrow/wrap and signed overflow corners
        send(4'd8, 4'd7, 1'b1);
        send(4'd5, 4'd10, 1'b0);
        send(4'b0111, 4'b1111, 1'b0);
        send(4'b1000, 4'b0001, 1'b0);
        send(4'd0, 4'd15, 1'b1);
        send(4'd15, 4'd15, 1'b1);
        drain();

        // Throughput: 16 back-to-back accepts in 16 cycles
        c0 = cyc;
        for (int i = 0; i < 16; i++) send(W'(i), W'(15 - i), 1'(i & 1));
        check("throughput_cycles", cyc - c0, 16);
        drain();

        // Backpressure: stream a = 0..15, b = 1, consumer stalled 5 cycles
        out_ready = 1'b0;
        in_valid = 1'b1;
        b = 4'd1;
        b_in = 1'b0;
        k = 0;
        for (int i = 0; i < 5; i++) begin
            a = W'(k);
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            if (hs) k++;
        end
        a = W'(k);
        @(negedge clk);
        check("bp_accepts", k, 2);
        check("bp_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid = 1'b0;
        while (k < 16) begin
            send(W'(k), 4'd1, 1'b0);
            k++;
        end
        drain();

        // Reset with both stages full: nothing in flight may emerge
        out_ready = 1'b0;
        send(4'd9, 4'd2, 1'b0);
        send(4'd3, 4'd4, 1'b1);
        @(negedge clk);
        check("full_in_ready", in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        repeat (4) @(posedge clk);
        #1;

        // Randomized stream with random consumer backpressure
        rnd_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 200; i++)
                    send(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();
        @(negedge clk);
        check("final_idle_valid", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
